// File: rtl/sample_player.sv
// ---------------------------------------------------------------------------
// sample_player
//
// Consumer side of the audio sample strobe. Each sample_tick fetches the next
// sample of a latched address window from a synchronous-read BRAM and presents
// it on sample_out. The window is played once (one-shot) or repeatedly (loop).
//
// Timing, counted from the cycle a tick is accepted (cycle 0):
//   cycle 1 : mem_rd_en high, mem_addr = current pointer
//   cycle 2 : mem_data valid from the BRAM
//   cycle 3 : sample_out updated, sample_valid pulse (and done on the final
//             one-shot sample)
//
// Optional build macro:
//   SAMPLE_PLAYER_REVERSE_EN - adds the 'reverse' input. When it is latched
//                              high on start, the window is played from
//                              end_addr down to start_addr.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   sample_tick   one-cycle sample-rate strobe
//   start         latch window/mode and begin playback
//   stop          abort playback and silence the output
//   loop_mode     1 = loop, 0 = one-shot (sampled on start)
//   reverse       play backwards (only with SAMPLE_PLAYER_REVERSE_EN)
//   start_addr    first sample address (sampled on start)
//   end_addr      last sample address, inclusive (sampled on start)
//   mem_addr      BRAM read address (registered)
//   mem_rd_en     BRAM read enable (registered)
//   mem_data      BRAM read data, valid the cycle after mem_rd_en
//   sample_out    current sample, holds between updates
//   sample_valid  one-cycle pulse when sample_out updates
//   busy          high from start until playback ends
//   done          one-cycle pulse when a one-shot playback completes
//   tick_missed   sticky flag: a tick arrived while a fetch was in progress
// ---------------------------------------------------------------------------
module sample_player #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
`ifdef SAMPLE_PLAYER_REVERSE_EN
    input  logic              reverse,
`endif
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              tick_missed
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        FETCH,
        CAPTURE
    } state_t;

    state_t state_q, state_nxt;

    logic [ADDR_W-1:0] ptr_q, ptr_nxt;
    logic [ADDR_W-1:0] start_q, start_nxt;
    logic [ADDR_W-1:0] end_q, end_nxt;
    logic              loop_q, loop_nxt;

    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              mem_rd_en_nxt;
    logic [DATA_W-1:0] sample_out_nxt;
    logic              sample_valid_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              tick_missed_nxt;

    // Direction handling: without the reverse feature the direction is a
    // constant forward, so the direction muxes below fold away.
    logic rev_q;
    logic start_rev;
`ifdef SAMPLE_PLAYER_REVERSE_EN
    logic rev_nxt;
    assign start_rev = reverse;
`else
    assign rev_q     = 1'b0;
    assign start_rev = 1'b0;
`endif

    // Terminal address, reload address and pointer step depend on direction.
    logic [ADDR_W-1:0] term_addr;
    logic [ADDR_W-1:0] reload_addr;
    logic [ADDR_W-1:0] ptr_step;

    assign term_addr   = rev_q ? start_q : end_q;
    assign reload_addr = rev_q ? end_q : start_q;
    assign ptr_step    = rev_q ? (ptr_q - ADDR_W'(1)) : (ptr_q + ADDR_W'(1));

    // Next-state and output logic. stop beats start, and start beats any tick
    // or fetch in flight, so an aborted fetch never produces a sample.
    always_comb begin
        state_nxt        = state_q;
        ptr_nxt          = ptr_q;
        start_nxt        = start_q;
        end_nxt          = end_q;
        loop_nxt         = loop_q;
        mem_addr_nxt     = mem_addr;
        mem_rd_en_nxt    = 1'b0;
        sample_out_nxt   = sample_out;
        sample_valid_nxt = 1'b0;
        busy_nxt         = busy;
        done_nxt         = 1'b0;
        tick_missed_nxt  = tick_missed;
`ifdef SAMPLE_PLAYER_REVERSE_EN
        rev_nxt          = rev_q;
`endif

        if (stop) begin
            state_nxt      = IDLE;
            busy_nxt       = 1'b0;
            sample_out_nxt = '0;
        end else if (start) begin
            state_nxt       = WAIT_TICK;
            start_nxt       = start_addr;
            end_nxt         = end_addr;
            loop_nxt        = loop_mode;
            ptr_nxt         = start_rev ? end_addr : start_addr;
            tick_missed_nxt = 1'b0;
            busy_nxt        = 1'b1;
`ifdef SAMPLE_PLAYER_REVERSE_EN
            rev_nxt         = reverse;
`endif
        end else begin
            // Ticks that land while a fetch is in flight are dropped.
            if (sample_tick && (state_q == FETCH || state_q == CAPTURE)) begin
                tick_missed_nxt = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    state_nxt = IDLE;
                end
                WAIT_TICK: begin
                    if (sample_tick) begin
                        state_nxt     = FETCH;
                        mem_addr_nxt  = ptr_q;
                        mem_rd_en_nxt = 1'b1;
                    end
                end
                FETCH: begin
                    state_nxt = CAPTURE;
                end
                CAPTURE: begin
                    sample_out_nxt   = mem_data;
                    sample_valid_nxt = 1'b1;
                    if (ptr_q != term_addr) begin
                        ptr_nxt   = ptr_step;
                        state_nxt = WAIT_TICK;
                    end else if (loop_q) begin
                        ptr_nxt   = reload_addr;
                        state_nxt = WAIT_TICK;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset overrides everything, even mid-fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            start_q      <= '0;
            end_q        <= '0;
            loop_q       <= 1'b0;
            mem_addr     <= '0;
            mem_rd_en    <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tick_missed  <= 1'b0;
`ifdef SAMPLE_PLAYER_REVERSE_EN
            rev_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_nxt;
            ptr_q        <= ptr_nxt;
            start_q      <= start_nxt;
            end_q        <= end_nxt;
            loop_q       <= loop_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_rd_en    <= mem_rd_en_nxt;
            sample_out   <= sample_out_nxt;
            sample_valid <= sample_valid_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            tick_missed  <= tick_missed_nxt;
`ifdef SAMPLE_PLAYER_REVERSE_EN
            rev_q        <= rev_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sample_player.sv
// ---------------------------------------------------------------------------
// tb_sample_player
//
// Drives sample_player through directed playback scenarios and a random
// phase. A BRAM stand-in returns addr*3 one cycle after each read, and a
// transaction-level player model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_sample_player;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_mode = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] end_addr = '0;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_data = '0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        done;
    logic        tick_missed;
`ifdef SAMPLE_PLAYER_REVERSE_EN
    logic        reverse = 1'b0;
`endif

    sample_player #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .start        (start),
        .stop         (stop),
        .loop_mode    (loop_mode),
`ifdef SAMPLE_PLAYER_REVERSE_EN
        .reverse      (reverse),
`endif
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_data     (mem_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done),
        .tick_missed  (tick_missed)
    );

    always #5 clk = ~clk;

    // Sample memory contents: each address holds three times its address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return a * 16'd3;
    endfunction

    // Synchronous-read BRAM stand-in.
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= memf(mem_addr);
    end

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Event logs used by the directed scenarios.
    int          tick_log[$];
    int          valid_log[$];
    int          done_log[$];
    logic [15:0] out_log[$];
    logic [15:0] addr_log[$];

    // Player model: m_fetch counts cycles since a tick was accepted.
    logic        m_busy, m_loop, m_rev, m_missed, m_valid, m_done, m_rden;
    logic [15:0] m_ptr, m_s, m_e, m_out, m_addr;
    int          m_fetch;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic clearLogs();
        tick_log.delete();
        valid_log.delete();
        done_log.delete();
        out_log.delete();
        addr_log.delete();
    endtask

    // Advances the model across one clock edge using the inputs just driven.
    task automatic modelEdge();
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (reset) begin
            m_busy = 0; m_loop = 0; m_rev = 0; m_missed = 0; m_rden = 0;
            m_ptr = '0; m_s = '0; m_e = '0; m_out = '0; m_addr = '0; m_fetch = 0;
        end else if (stop) begin
            m_busy  = 1'b0;
            m_fetch = 0;
            m_rden  = 1'b0;
            m_out   = '0;
        end else if (start) begin
            m_s    = start_addr;
            m_e    = end_addr;
            m_loop = loop_mode;
`ifdef SAMPLE_PLAYER_REVERSE_EN
            m_rev  = reverse;
`else
            m_rev  = 1'b0;
`endif
            m_ptr    = m_rev ? end_addr : start_addr;
            m_missed = 1'b0;
            m_busy   = 1'b1;
            m_fetch  = 0;
            m_rden   = 1'b0;
        end else begin
            m_rden = 1'b0;
            if (m_busy) begin
                if (m_fetch != 0 && sample_tick) m_missed = 1'b1;
                if (m_fetch == 0) begin
                    if (sample_tick) begin
                        m_fetch = 1;
                        m_addr  = m_ptr;
                        m_rden  = 1'b1;
                    end
                end else if (m_fetch == 1) begin
                    m_fetch = 2;
                end else begin
                    m_fetch = 0;
                    m_out   = memf(m_addr);
                    m_valid = 1'b1;
                    if (m_ptr == (m_rev ? m_s : m_e)) begin
                        if (m_loop) m_ptr = m_rev ? m_e : m_s;
                        else begin
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end
                    end else begin
                        m_ptr = m_rev ? m_ptr - 16'd1 : m_ptr + 16'd1;
                    end
                end
            end
        end
    endtask

    // One clock cycle: drive control inputs, step model, compare all outputs.
    task automatic applyStimulus(input logic tk, input logic st, input logic sp, input logic rst);
        sample_tick = tk;
        start       = st;
        stop        = sp;
        reset       = rst;
        if (tk) tick_log.push_back(cycle);
        @(posedge clk);
        modelEdge();
        #1;
        cycle++;
        checkOutput("sample_valid", sample_valid, m_valid);
        checkOutput("done", done, m_done);
        checkOutput("busy", busy, m_busy);
        checkOutput("mem_rd_en", mem_rd_en, m_rden);
        checkOutput("tick_missed", tick_missed, m_missed);
        checkOutput("sample_out", sample_out, m_out);
        checkOutput("mem_addr", mem_addr, m_addr);
        if (sample_valid) begin
            valid_log.push_back(cycle);
            out_log.push_back(sample_out);
        end
        if (done) done_log.push_back(cycle);
        if (mem_rd_en) addr_log.push_back(mem_addr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic startWindow(input logic [15:0] sa, input logic [15:0] ea, input logic lp);
        start_addr = sa;
        end_addr   = ea;
        loop_mode  = lp;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] sample_player bench starting");

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_out", sample_out, 16'h0000);
        checkOutput("reset_addr", mem_addr, 16'h0000);

        // One-shot 0x10..0x13, ticks every 2268 cycles, fifth tick ignored
        clearLogs();
        startWindow(16'h0010, 16'h0013, 1'b0);
        for (int t = 0; t < 5; t++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            idle(2267);
        end
        checkOutput("oneshot_nreads", addr_log.size(), 4);
        checkOutput("oneshot_nvalid", out_log.size(), 4);
        if (addr_log.size() == 4 && out_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("oneshot_addr", addr_log[i], 16'h0010 + 16'(i));
                checkOutput("oneshot_sample", out_log[i], 16'h0030 + 16'(3 * i));
                checkOutput("oneshot_latency", valid_log[i] - tick_log[i], 3);
            end
            checkOutput("oneshot_done_n", done_log.size(), 1);
            if (done_log.size() == 1) checkOutput("oneshot_done_cycle", done_log[0], valid_log[3]);
        end
        checkOutput("oneshot_busy_after", busy, 1'b0);
        checkOutput("oneshot_hold", sample_out, 16'h0039);

        // Loop across the top of memory
        clearLogs();
        startWindow(16'hFFFE, 16'h0001, 1'b1);
        for (int t = 0; t < 6; t++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            idle(9);
        end
        checkOutput("loop_nreads", addr_log.size(), 6);
        if (addr_log.size() == 6) begin
            checkOutput("loop_a0", addr_log[0], 16'hFFFE);
            checkOutput("loop_a1", addr_log[1], 16'hFFFF);
            checkOutput("loop_a2", addr_log[2], 16'h0000);
            checkOutput("loop_a3", addr_log[3], 16'h0001);
            checkOutput("loop_a4", addr_log[4], 16'hFFFE);
            checkOutput("loop_a5", addr_log[5], 16'hFFFF);
        end
        checkOutput("loop_no_done", done_log.size(), 0);
        checkOutput("loop_busy", busy, 1'b1);

        // Missed tick: two ticks one cycle apart
        clearLogs();
        startWindow(16'h0040, 16'h004F, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);
        checkOutput("missed_nvalid", out_log.size(), 1);
        checkOutput("missed_flag", tick_missed, 1'b1);
        startWindow(16'h0040, 16'h004F, 1'b0);
        checkOutput("missed_cleared", tick_missed, 1'b0);

        // Stop in the FETCH cycle
        clearLogs();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("stop_busy", busy, 1'b0);
        checkOutput("stop_out", sample_out, 16'h0000);
        idle(5);
        checkOutput("stop_nvalid", out_log.size(), 0);
        checkOutput("stop_no_done", done_log.size(), 0);

        // start and stop together from IDLE stays idle
        clearLogs();
        start_addr = 16'h0200;
        end_addr   = 16'h0203;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("startstop_busy", busy, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        checkOutput("startstop_nreads", addr_log.size(), 0);

        // Restart mid-fetch: aborted fetch gives no sample, next tick reads new start
        clearLogs();
        startWindow(16'h0000, 16'h00FF, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        start_addr = 16'h0100;
        end_addr   = 16'h0110;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        checkOutput("restart_nvalid", out_log.size(), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        checkOutput("restart_nreads", addr_log.size(), 2);
        if (addr_log.size() == 2) checkOutput("restart_addr", addr_log[1], 16'h0100);
        checkOutput("restart_sample", sample_out, 16'h0300);

        // Reset asserted in CAPTURE
        clearLogs();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_valid", sample_valid, 1'b0);
        checkOutput("rst_out", sample_out, 16'h0000);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_addr", mem_addr, 16'h0000);
        idle(3);
        checkOutput("rst_nvalid", out_log.size(), 0);

`ifdef SAMPLE_PLAYER_REVERSE_EN
        // Reverse one-shot 0x20..0x22
        clearLogs();
        reverse = 1'b1;
        startWindow(16'h0020, 16'h0022, 1'b0);
        reverse = 1'b0;
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            idle(6);
        end
        checkOutput("rev_nreads", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            checkOutput("rev_a0", addr_log[0], 16'h0022);
            checkOutput("rev_a1", addr_log[1], 16'h0021);
            checkOutput("rev_a2", addr_log[2], 16'h0020);
        end
        checkOutput("rev_done_n", done_log.size(), 1);
        if (done_log.size() == 1 && valid_log.size() == 3)
            checkOutput("rev_done_cycle", done_log[0], valid_log[2]);
`endif

        // Random phase checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] base;
            logic [15:0] span;
            base = 16'($urandom);
            if ($urandom_range(0, 7) == 0) base = 16'hFFFC;
            span = 16'($urandom_range(0, 5));
            start_addr = base;
            end_addr   = base + span;
            loop_mode  = 1'($urandom_range(0, 1));
`ifdef SAMPLE_PLAYER_REVERSE_EN
            reverse    = 1'($urandom_range(0, 1));
`endif
            applyStimulus($urandom_range(0, 5) == 0,
                          $urandom_range(0, 79) == 0,
                          $urandom_range(0, 249) == 0,
                          $urandom_range(0, 999) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
